// File: rtl/branch_trace_driver.sv
// Branch-predictor initiator: accepts resolved outcomes, queries and trains the
// predictor, scores each prediction and keeps saturating hit/miss statistics.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready for the next outcome from upstream
// S_QUERY  | one-cycle query strobe (result) to the predictor
// S_WAIT   | counting down to the prediction sample point
// S_UPDATE | one-cycle training strobe (request), score and count
module branch_trace_driver #(
  parameter int CNT_W    = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic             br_taken,
  output logic             br_ready,
  output logic             request,
  output logic             taken,
  output logic             result,
  input  logic             prediction,
  output logic             pred_valid,
  output logic             pred_hit,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUERY,
    S_WAIT,
    S_UPDATE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_wait;
  logic             r_out_q;
  logic             r_request;
  logic             r_result;
  logic             r_taken;
  logic             r_pred_valid;
  logic             r_pred_hit;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_hit;
  logic [CNT_W-1:0] r_miss;
  logic             w_enter_upd;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (br_valid) w_state_nxt = S_QUERY;
      S_QUERY:  w_state_nxt = S_WAIT;
      S_WAIT:   if (r_wait == 4'd1) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_upd = (w_state_nxt == S_UPDATE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_out_q      <= 1'b0;
      r_request    <= 1'b0;
      r_result     <= 1'b0;
      r_taken      <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_hit   <= 1'b0;
      r_total      <= '0;
      r_hit        <= '0;
      r_miss       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_result     <= (w_state_nxt == S_QUERY);
      r_request    <= w_enter_upd;
      r_pred_valid <= w_enter_upd;
      // The prediction is captured directly as the score on the sample edge.
      r_pred_hit   <= w_enter_upd && (prediction == r_out_q);
      if (w_enter_upd) r_taken <= r_out_q;

      if (r_state == S_IDLE && br_valid) r_out_q <= br_taken;

      if (r_state == S_QUERY)     r_wait <= 4'(WAIT_CYC);
      else if (r_state == S_WAIT) r_wait <= r_wait - 4'd1;

      if (clr_stats) begin
        r_total <= '0;
        r_hit   <= '0;
        r_miss  <= '0;
      end else if (r_state == S_UPDATE) begin
        if (!(&r_total)) r_total <= r_total + CNT_W'(1);
        if (r_pred_hit) begin
          if (!(&r_hit)) r_hit <= r_hit + CNT_W'(1);
        end else begin
          if (!(&r_miss)) r_miss <= r_miss + CNT_W'(1);
        end
      end
    end
  end

  assign br_ready   = (r_state == S_IDLE) && rst_n;
  assign busy       = (r_state != S_IDLE);
  assign request    = r_request;
  assign result     = r_result;
  assign taken      = r_taken;
  assign pred_valid = r_pred_valid;
  assign pred_hit   = r_pred_hit;
  assign total_cnt  = r_total;
  assign hit_cnt    = r_hit;
  assign miss_cnt   = r_miss;

endmodule

// File: tb/tb_branch_trace_driver.sv
// Bench for branch_trace_driver: two instances (default, and CNT_W=2/WAIT_CYC=3)
// scored every cycle against a branch-timeline model and a 2-bit predictor.
module tb_branch_trace_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic rst_n_v[2];
  logic br_valid_v[2];
  logic br_taken_v[2];
  logic clr_v[2];
  logic br_ready_v[2];
  logic request_v[2];
  logic taken_v[2];
  logic result_v[2];
  logic prediction_v[2];
  logic pred_valid_v[2];
  logic pred_hit_v[2];
  logic busy_v[2];
  logic [15:0] tot0, hit0, miss0;
  logic [1:0]  tot1, hit1, miss1;

  logic [1:0] pctr[2]     = '{2'b00, 2'b00};
  logic       pred_clr[2] = '{1'b0, 1'b0};

  branch_trace_driver u_dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .br_valid(br_valid_v[0]), .br_taken(br_taken_v[0]),
    .br_ready(br_ready_v[0]), .request(request_v[0]), .taken(taken_v[0]),
    .result(result_v[0]), .prediction(prediction_v[0]), .pred_valid(pred_valid_v[0]),
    .pred_hit(pred_hit_v[0]), .clr_stats(clr_v[0]), .total_cnt(tot0),
    .hit_cnt(hit0), .miss_cnt(miss0), .busy(busy_v[0])
  );

  branch_trace_driver #(.CNT_W(2), .WAIT_CYC(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .br_valid(br_valid_v[1]), .br_taken(br_taken_v[1]),
    .br_ready(br_ready_v[1]), .request(request_v[1]), .taken(taken_v[1]),
    .result(result_v[1]), .prediction(prediction_v[1]), .pred_valid(pred_valid_v[1]),
    .pred_hit(pred_hit_v[1]), .clr_stats(clr_v[1]), .total_cnt(tot1),
    .hit_cnt(hit1), .miss_cnt(miss1), .busy(busy_v[1])
  );

  // 2-bit saturating predictor: predicts taken when the counter is 2 or 3.
  assign prediction_v[0] = pctr[0][1];
  assign prediction_v[1] = pctr[1][1];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pred_clr[i])       pctr[i] <= 2'b00;
      else if (request_v[i]) begin
        if (taken_v[i]) pctr[i] <= (pctr[i] == 2'b11) ? 2'b11 : pctr[i] + 2'b01;
        else            pctr[i] <= (pctr[i] == 2'b00) ? 2'b00 : pctr[i] - 2'b01;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int cmax(input int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  function automatic logic [31:0] get_tot(input int i);
    return (i == 0) ? {16'b0, tot0} : {30'b0, tot1};
  endfunction

  function automatic logic [31:0] get_hit(input int i);
    return (i == 0) ? {16'b0, hit0} : {30'b0, hit1};
  endfunction

  function automatic logic [31:0] get_miss(input int i);
    return (i == 0) ? {16'b0, miss0} : {30'b0, miss1};
  endfunction

  // Reference model: age = cycles since the accept cycle (-1 when idle).
  // Query at age 1, prediction sampled at the end of age 1+W, update at age 2+W.
  int age[2]     = '{-1, -1};
  int exp_tot[2] = '{0, 0};
  int exp_hc[2]  = '{0, 0};
  int exp_mc[2]  = '{0, 0};
  bit exp_out[2] = '{0, 0};
  bit exp_hit[2] = '{0, 0};
  bit exp_tk[2]  = '{0, 0};

  always @(negedge clk) begin : model_chk
    int w;
    int mx;
    bit in_upd;
    for (int i = 0; i < 2; i++) begin
      w      = wc(i);
      mx     = cmax(i);
      in_upd = (age[i] == 2 + w);
      check($sformatf("%0d.br_ready", i), br_ready_v[i], (age[i] == -1) && rst_n_v[i]);
      check($sformatf("%0d.busy", i), busy_v[i], age[i] != -1);
      check($sformatf("%0d.result", i), result_v[i], age[i] == 1);
      check($sformatf("%0d.request", i), request_v[i], in_upd);
      check($sformatf("%0d.pred_valid", i), pred_valid_v[i], in_upd);
      if (in_upd) begin
        check($sformatf("%0d.pred_hit", i), pred_hit_v[i], exp_hit[i]);
        check($sformatf("%0d.taken_upd", i), taken_v[i], exp_out[i]);
      end else begin
        check($sformatf("%0d.taken_hold", i), taken_v[i], exp_tk[i]);
      end
      check($sformatf("%0d.total_cnt", i), get_tot(i), exp_tot[i]);
      check($sformatf("%0d.hit_cnt", i), get_hit(i), exp_hc[i]);
      check($sformatf("%0d.miss_cnt", i), get_miss(i), exp_mc[i]);

      if (!rst_n_v[i]) begin
        age[i] = -1; exp_tot[i] = 0; exp_hc[i] = 0; exp_mc[i] = 0; exp_tk[i] = 0;
      end else begin
        if (age[i] == -1) begin
          if (br_valid_v[i]) begin
            age[i]     = 1;
            exp_out[i] = br_taken_v[i];
          end
        end else if (age[i] == 2 + w) begin
          age[i]    = -1;
          exp_tk[i] = exp_out[i];
          if (exp_tot[i] < mx) exp_tot[i]++;
          if (exp_hit[i]) begin
            if (exp_hc[i] < mx) exp_hc[i]++;
          end else begin
            if (exp_mc[i] < mx) exp_mc[i]++;
          end
        end else begin
          if (age[i] == 1 + w) exp_hit[i] = (prediction_v[i] == exp_out[i]);
          age[i]++;
        end
        if (clr_v[i]) begin
          exp_tot[i] = 0; exp_hc[i] = 0; exp_mc[i] = 0;
        end
      end
    end
  end

  // All driver tasks start and end at posedge+#1.
  task automatic send(input int i, input bit t);
    bit acc = 0;
    br_valid_v[i] = 1'b1;
    br_taken_v[i] = t;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = br_ready_v[i];
      @(posedge clk); #1;
    end
    br_valid_v[i] = 1'b0;
    br_taken_v[i] = 1'($urandom_range(0, 1));
    if (!acc) check($sformatf("%0d.accept_timeout", i), 0, 1);
  endtask

  task automatic wait_idle(input int i);
    int k = 0;
    @(negedge clk);
    while (busy_v[i] && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy_v[i]) check($sformatf("%0d.idle_timeout", i), 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic stream(input int i, input int n);
    int acc = 0, last = -1, cyc = 0, nreq = 0;
    br_valid_v[i] = 1'b1;
    br_taken_v[i] = 1'b1;
    while (acc < n && cyc < 500) begin
      @(negedge clk);
      if (request_v[i]) nreq++;
      if (br_ready_v[i]) begin
        if (last >= 0) check($sformatf("%0d.accept_gap", i), cyc - last, 3 + wc(i));
        last = cyc;
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    br_valid_v[i] = 1'b0;
    repeat (3 + wc(i)) begin
      @(negedge clk);
      if (request_v[i]) nreq++;
      @(posedge clk); #1;
    end
    check($sformatf("%0d.stream_accepts", i), acc, n);
    check($sformatf("%0d.stream_requests", i), nreq, n);
  endtask

  task automatic cnt_check(input int i, input int t, input int h, input int m);
    @(negedge clk);
    check($sformatf("%0d.final_total", i), get_tot(i), t);
    check($sformatf("%0d.final_hit", i), get_hit(i), h);
    check($sformatf("%0d.final_miss", i), get_miss(i), m);
    @(posedge clk); #1;
  endtask

  task automatic fresh(input int i);
    clr_v[i]    = 1'b1;
    pred_clr[i] = 1'b1;
    @(posedge clk); #1;
    clr_v[i]    = 1'b0;
    pred_clr[i] = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      rst_n_v[i] = 1'b0; br_valid_v[i] = 1'b0; br_taken_v[i] = 1'b0; clr_v[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n_v[0] = 1'b1;
    rst_n_v[1] = 1'b1;
    cnt_check(0, 0, 0, 0);

    // Trace T,T,T,N against a fresh predictor.
    fresh(0);
    send(0, 1); send(0, 1); send(0, 1); send(0, 0);
    wait_idle(0);
    cnt_check(0, 4, 1, 3);

    // Eight taken outcomes with br_valid held high.
    fresh(0);
    stream(0, 8);
    cnt_check(0, 8, 6, 2);

    // Narrow counters: five taken branches.
    fresh(1);
    repeat (5) send(1, 1);
    wait_idle(1);
    cnt_check(1, 3, 3, 2);

    // Occupancy with WAIT_CYC=3: accept cycle plus busy cycles.
    send(1, 0);
    n = 0;
    @(negedge clk);
    while (busy_v[1] && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("1.occupancy", n + 1, 6);
    @(posedge clk); #1;

    // Clear coinciding with UPDATE drops that score.
    fresh(0);
    send(0, 1);
    wait_idle(0);
    send(0, 1);
    repeat (wc(0) + 1) begin @(posedge clk); #1; end
    clr_v[0] = 1'b1;
    @(negedge clk);
    check("0.clr_pred_valid", pred_valid_v[0], 1);
    @(posedge clk); #1;
    clr_v[0] = 1'b0;
    cnt_check(0, 0, 0, 0);

    // Reset during WAIT abandons the branch.
    send(0, 0);
    wait_idle(0);
    send(0, 1);
    @(posedge clk); #1;
    rst_n_v[0] = 1'b0;
    @(posedge clk); #1;
    rst_n_v[0] = 1'b1;
    @(negedge clk);
    check("0.ready_after_rst", br_ready_v[0], 1);
    check("0.total_after_rst", get_tot(0), 0);
    @(posedge clk); #1;
    send(0, 0);
    wait_idle(0);
    cnt_check(0, 1, 1, 0);

    // Random traffic, clears and resets on both instances.
    repeat (3000) begin
      for (int i = 0; i < 2; i++) begin
        br_valid_v[i] = 1'($urandom_range(0, 1));
        br_taken_v[i] = 1'($urandom_range(0, 1));
        clr_v[i]      = ($urandom_range(0, 31) == 0);
        rst_n_v[i]    = ($urandom_range(0, 63) != 0);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      br_valid_v[i] = 1'b0; clr_v[i] = 1'b0; rst_n_v[i] = 1'b1;
    end
    repeat (8) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
